uart_cmd_engine: RTL and testbench

Parametrised UART register-access command engine. It sits between the UART RX/TX byte streams and the UART register file. It decodes one command byte, then either reads a register of `DATA_BYTES` bytes and streams it out little-endian, or collects `DATA_BYTES` payload bytes and issues one write. It adds three things to single-byte access: TX backpressure, an inter-byte timeout on write payloads, and ACK/NAK response bytes.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_cmd_engine_if.sv | 39 +++
 rtl/uart_cmd_timeout.sv | 37 +++
 rtl/uart_cmd_engine.sv | 206 ++++++++++++++++++++
 tb/tb_uart_cmd_engine.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-access command engine.
//   cmd_state_t       : command engine FSM states
//   CMD_ACK / CMD_NAK : response bytes for completed writes / rejected commands
//   CMD_WR_BIT        : command byte bit holding the write flag
//   CMD_ADDR_LSB      : lowest command byte bit of the register address
//   UART_DOUTL_OFFSET : register address of the RX FIFO data port
package uart_pkg;

    localparam int         UART_DOUTL_OFFSET = 0;

    localparam logic [7:0] CMD_ACK      = 8'hA5;
    localparam logic [7:0] CMD_NAK      = 8'h5A;

    localparam int         CMD_WR_BIT   = 0;
    localparam int         CMD_ADDR_LSB = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_CAP,
        ST_TX_DATA,
        ST_GET_DATA,
        ST_WR_REQ,
        ST_TX_ACK,
        ST_TX_NAK
    } cmd_state_t;

    // True when any bit above the address field is set. With a 7-bit
    // address the shift clears the whole byte, so nothing is reserved.
    function automatic logic cmd_reserved_set(input logic [7:0] cmd, input int addr_w);
        logic [7:0] hi;
        hi = cmd >> (addr_w + 1);
        return (hi != 8'h00);
    endfunction

endpackage

// File: rtl/uart_cmd_engine_if.sv
// Signal bundle between the command engine and its environment
// (UART RX/TX byte streams and the register file).
//   master : the command engine (drives o_*, samples i_*)
//   slave  : the UART core / register file side
//
// TX handshake: o_tx_data_valid rises with a byte on o_tx_data; both stay
// frozen until a rising edge sees o_tx_data_valid && i_tx_ready, which is
// the single transfer point. i_rx_data_valid is a one-cycle strobe with no
// ready; bytes arriving when the engine cannot take them are lost.
interface uart_cmd_engine_if #(
    parameter int ADDR_W     = 3,
    parameter int DATA_BYTES = 1
);
    logic [7:0]              i_rx_data;
    logic                    i_rx_data_valid;
    logic [7:0]              o_tx_data;
    logic                    o_tx_data_valid;
    logic                    i_tx_ready;
    logic [ADDR_W-1:0]       o_addr;
    logic                    o_rd_req;
    logic [8*DATA_BYTES-1:0] i_rd_data;
    logic                    o_wr_req;
    logic [8*DATA_BYTES-1:0] o_wr_data;
    logic                    o_fifo_fetch;
    logic                    o_busy;
    logic                    o_timeout;

    modport master (
        input  i_rx_data, i_rx_data_valid, i_tx_ready, i_rd_data,
        output o_tx_data, o_tx_data_valid, o_addr, o_rd_req, o_wr_req,
               o_wr_data, o_fifo_fetch, o_busy, o_timeout
    );

    modport slave (
        output i_rx_data, i_rx_data_valid, i_tx_ready, i_rd_data,
        input  o_tx_data, o_tx_data_valid, o_addr, o_rd_req, o_wr_req,
               o_wr_data, o_fifo_fetch, o_busy, o_timeout
    );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout for write payloads: a loadable down-counter.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_load         : reload to TIMEOUT_CYC-1 (start of payload / byte received)
//   i_en           : count down while waiting for payload
//   o_expired      : high in the cycle the count has run out while enabled
// Loading TIMEOUT_CYC-1 and expiring at zero fires on the TIMEOUT_CYC-th
// idle cycle, the same point an up-counter reaching TIMEOUT_CYC-1 would.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = LOAD_VAL;
        end else if (i_en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);   // saturates at zero
        end
    end

    assign o_expired = i_en && (cnt_q == '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_cmd_engine.sv
// UART register-access command engine. Decodes a command byte, then either
// reads a DATA_BYTES-wide register and streams it out LSB first, or collects
// DATA_BYTES payload bytes and issues one write (optionally ACKed). Bad
// commands and abandoned payloads are answered with a NAK byte.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (master)   : RX strobe/byte, TX valid/ready/byte, register read/write
//                    strobes with address and data, FIFO pop, busy, timeout
// Every output is a flop; each is loaded on the edge that enters the state
// it belongs to, so strobes line up with the state they describe.
module uart_cmd_engine
    import uart_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int DATA_BYTES  = 1,
    parameter int FIFO_ADDR   = UART_DOUTL_OFFSET,
    parameter int TIMEOUT_CYC = 100000,
    parameter int WRITE_ACK   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    uart_cmd_engine_if.master bus
);
    localparam int                DW       = 8 * DATA_BYTES;
    localparam int                BCW      = $clog2(DATA_BYTES + 1);
    localparam logic [BCW-1:0]    LAST_IDX = BCW'(DATA_BYTES - 1);
    localparam logic [ADDR_W-1:0] FIFO_A   = ADDR_W'(FIFO_ADDR);

    cmd_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     shift_q, shift_d;     // read data or write payload
    logic [BCW-1:0]    idx_q, idx_d;         // byte lane index
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rd_req_q, rd_req_d;
    logic              wr_req_q, wr_req_d;
    logic [DW-1:0]     wr_data_q, wr_data_d;
    logic              fifo_fetch_q, fifo_fetch_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic              tmo_load, tmo_en, tmo_expired;
    logic              tx_accept;
    logic [ADDR_W-1:0] rx_addr;
    logic [DW-1:0]     shift_nx;

    assign tmo_en    = (state_q == ST_GET_DATA);
    assign tx_accept = tx_valid_q && bus.i_tx_ready;
    assign rx_addr   = bus.i_rx_data[CMD_ADDR_LSB +: ADDR_W];
    assign shift_nx  = shift_q >> 8;

    uart_cmd_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (tmo_load),
        .i_en     (tmo_en),
        .o_expired(tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        shift_d      = shift_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        wr_data_d    = wr_data_q;
        rd_req_d     = 1'b0;
        wr_req_d     = 1'b0;
        fifo_fetch_d = 1'b0;
        timeout_d    = 1'b0;
        tmo_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_rx_data_valid) begin
                    if (cmd_reserved_set(bus.i_rx_data, ADDR_W)) begin
                        state_d    = ST_TX_NAK;
                        tx_data_d  = CMD_NAK;
                        tx_valid_d = 1'b1;
                    end else if (!bus.i_rx_data[CMD_WR_BIT]) begin
                        state_d      = ST_RD_REQ;
                        addr_d       = rx_addr;
                        rd_req_d     = 1'b1;
                        fifo_fetch_d = (rx_addr == FIFO_A);
                    end else begin
                        state_d  = ST_GET_DATA;
                        addr_d   = rx_addr;
                        idx_d    = '0;
                        shift_d  = '0;
                        tmo_load = 1'b1;
                    end
                end
            end

            ST_RD_REQ: state_d = ST_RD_CAP;

            // Read data is valid now; present lane 0 straight away.
            ST_RD_CAP: begin
                state_d    = ST_TX_DATA;
                shift_d    = bus.i_rd_data;
                idx_d      = '0;
                tx_data_d  = bus.i_rd_data[7:0];
                tx_valid_d = 1'b1;
            end

            ST_TX_DATA: begin
                if (tx_accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                    end else begin
                        idx_d     = idx_q + BCW'(1);
                        shift_d   = shift_nx;
                        tx_data_d = shift_nx[7:0];
                    end
                end
            end

            // Expiry is checked first so a byte landing on that cycle is lost.
            ST_GET_DATA: begin
                if (tmo_expired) begin
                    state_d    = ST_TX_NAK;
                    timeout_d  = 1'b1;
                    shift_d    = '0;
                    tx_data_d  = CMD_NAK;
                    tx_valid_d = 1'b1;
                end else if (bus.i_rx_data_valid) begin
                    for (int i = 0; i < DATA_BYTES; i++) begin
                        if (idx_q == BCW'(i)) shift_d[8*i +: 8] = bus.i_rx_data;
                    end
                    tmo_load = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d   = ST_WR_REQ;
                        wr_req_d  = 1'b1;
                        wr_data_d = shift_d;
                    end else begin
                        idx_d = idx_q + BCW'(1);
                    end
                end
            end

            ST_WR_REQ: begin
                if (WRITE_ACK != 0) begin
                    state_d    = ST_TX_ACK;
                    tx_data_d  = CMD_ACK;
                    tx_valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_TX_ACK, ST_TX_NAK: begin
                if (tx_accept) begin
                    state_d    = ST_IDLE;
                    tx_valid_d = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            wr_data_q    <= '0;
            fifo_fetch_q <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            shift_q      <= shift_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            rd_req_q     <= rd_req_d;
            wr_req_q     <= wr_req_d;
            wr_data_q    <= wr_data_d;
            fifo_fetch_q <= fifo_fetch_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.o_tx_data       = tx_data_q;
    assign bus.o_tx_data_valid = tx_valid_q;
    assign bus.o_addr          = addr_q;
    assign bus.o_rd_req        = rd_req_q;
    assign bus.o_wr_req        = wr_req_q;
    assign bus.o_wr_data       = wr_data_q;
    assign bus.o_fifo_fetch    = fifo_fetch_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_timeout       = timeout_q;
endmodule

// File: tb/tb_uart_cmd_engine.sv
// Bench for uart_cmd_engine with ADDR_W=3, DATA_BYTES=2, FIFO at address 0
// and a short payload timeout. Expected TX bytes are queued by the
// transaction tasks from the command rules and popped by a monitor.
module tb_uart_cmd_engine;

    localparam int         AW      = 3;
    localparam int         DB      = 2;
    localparam int         DW      = 8 * DB;
    localparam int         TMO     = 20;
    localparam logic [7:0] EXP_ACK = 8'hA5;
    localparam logic [7:0] EXP_NAK = 8'h5A;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_engine_if #(.ADDR_W(AW), .DATA_BYTES(DB)) bus ();

    uart_cmd_engine #(
        .ADDR_W     (AW),
        .DATA_BYTES (DB),
        .FIFO_ADDR  (0),
        .TIMEOUT_CYC(TMO),
        .WRITE_ACK  (1)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];
    int          rd_cnt, wr_cnt, ff_cnt, to_cnt;
    logic [AW-1:0] last_rd_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor samples just before each rising edge, after the bench has
    // settled its inputs on the falling edge.
    always begin
        @(negedge clk);
        #3;
        if (rst_n) begin
            if (bus.o_rd_req) begin
                rd_cnt++;
                last_rd_addr = bus.o_addr;
            end
            if (bus.o_wr_req)     wr_cnt++;
            if (bus.o_fifo_fetch) ff_cnt++;
            if (bus.o_timeout)    to_cnt++;
            if (bus.o_tx_data_valid && bus.i_tx_ready) begin
                if (exp_q.size() == 0) check("tx_extra_byte", 32'(exp_q.size()), 32'd1);
                else                   check("tx_byte", {24'd0, bus.o_tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; ff_cnt = 0; to_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_rx_data       = b;
        bus.i_rx_data_valid = 1'b1;
        @(negedge clk);
        bus.i_rx_data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((bus.o_busy || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_wait"}, 32'(n < 100), 32'd1);
    endtask

    task automatic check_reset_zero(input string tag);
        check({tag, "_tx_data"},    32'(bus.o_tx_data),       32'd0);
        check({tag, "_tx_valid"},   32'(bus.o_tx_data_valid), 32'd0);
        check({tag, "_rd_req"},     32'(bus.o_rd_req),        32'd0);
        check({tag, "_wr_req"},     32'(bus.o_wr_req),        32'd0);
        check({tag, "_wr_data"},    32'(bus.o_wr_data),       32'd0);
        check({tag, "_fifo_fetch"}, 32'(bus.o_fifo_fetch),    32'd0);
        check({tag, "_busy"},       32'(bus.o_busy),          32'd0);
        check({tag, "_timeout"},    32'(bus.o_timeout),       32'd0);
        check({tag, "_addr"},       32'(bus.o_addr),          32'd0);
    endtask

    // Read: register bytes go out least significant first.
    task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int stall);
        clear_counts();
        bus.i_rd_data  = data;
        bus.i_tx_ready = (stall == 0);
        for (int i = 0; i < DB; i++) exp_q.push_back(data[8*i +: 8]);
        send_byte({4'b0000, addr, 1'b0});
        check("rd_strobe",     32'(bus.o_rd_req),       32'd1);
        check("rd_addr",       32'(bus.o_addr),         32'(addr));
        check("rd_fifo_fetch", 32'(bus.o_fifo_fetch),   32'(addr == 0));
        check("rd_busy",       32'(bus.o_busy),         32'd1);
        @(negedge clk);
        check("rd_strobe_end", 32'(bus.o_rd_req),       32'd0);
        check("rd_no_tx_yet",  32'(bus.o_tx_data_valid), 32'd0);
        @(negedge clk);
        check("rd_tx_valid",   32'(bus.o_tx_data_valid), 32'd1);
        check("rd_tx_first",   32'(bus.o_tx_data),      32'(data[7:0]));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("rd_stall_valid", 32'(bus.o_tx_data_valid), 32'd1);
            check("rd_stall_data",  32'(bus.o_tx_data),       32'(data[7:0]));
        end
        bus.i_tx_ready = 1'b1;
        wait_idle("rd");
        check("rd_count",     32'(rd_cnt),       32'd1);
        check("rd_no_write",  32'(wr_cnt),       32'd0);
        check("rd_fifo_cnt",  32'(ff_cnt),       32'(addr == 0));
        check("rd_addr_seen", 32'(last_rd_addr), 32'(addr));
    endtask

    // Write: payload lanes arrive LSB first with given idle gaps before each.
    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input int g0, input int g1);
        int gaps[DB];
        gaps[0] = g0;
        gaps[1] = g1;
        clear_counts();
        bus.i_tx_ready = 1'b1;
        exp_q.push_back(EXP_ACK);
        send_byte({4'b0000, addr, 1'b1});
        check("wr_busy",    32'(bus.o_busy),          32'd1);
        check("wr_no_tx",   32'(bus.o_tx_data_valid), 32'd0);
        for (int i = 0; i < DB; i++) begin
            repeat (gaps[i]) @(negedge clk);
            send_byte(data[8*i +: 8]);
        end
        check("wr_strobe",  32'(bus.o_wr_req),  32'd1);
        check("wr_data",    32'(bus.o_wr_data), 32'(data));
        check("wr_addr",    32'(bus.o_addr),    32'(addr));
        @(negedge clk);
        check("wr_strobe_end", 32'(bus.o_wr_req),        32'd0);
        check("wr_ack_valid",  32'(bus.o_tx_data_valid), 32'd1);
        check("wr_ack_byte",   32'(bus.o_tx_data),       32'(EXP_ACK));
        wait_idle("wr");
        check("wr_count",      32'(wr_cnt), 32'd1);
        check("wr_no_read",    32'(rd_cnt), 32'd0);
        check("wr_no_timeout", 32'(to_cnt), 32'd0);
    endtask

    // Payload abandoned after TMO silent cycles; with race=1 a byte lands
    // on exactly the expiring cycle and must be discarded.
    task automatic do_timeout(input bit race);
        clear_counts();
        bus.i_tx_ready = 1'b1;
        exp_q.push_back(EXP_NAK);
        send_byte(8'h03);
        send_byte(8'h34);
        repeat (TMO - 1) @(negedge clk);
        check("tmo_not_early", 32'(bus.o_timeout), 32'd0);
        check("tmo_busy",      32'(bus.o_busy),    32'd1);
        if (race) send_byte(8'h12);
        else      @(negedge clk);
        check("tmo_pulse",     32'(bus.o_timeout),       32'd1);
        check("tmo_nak_valid", 32'(bus.o_tx_data_valid), 32'd1);
        check("tmo_nak_byte",  32'(bus.o_tx_data),       32'(EXP_NAK));
        @(negedge clk);
        check("tmo_pulse_end", 32'(bus.o_timeout), 32'd0);
        wait_idle("tmo");
        repeat (3) @(negedge clk);
        check("tmo_stays_idle", 32'(bus.o_busy), 32'd0);
        check("tmo_count",      32'(to_cnt),     32'd1);
        check("tmo_no_write",   32'(wr_cnt),     32'd0);
    endtask

    task automatic do_reserved(input logic [7:0] b);
        clear_counts();
        bus.i_tx_ready = 1'b1;
        exp_q.push_back(EXP_NAK);
        send_byte(b);
        check("rsv_nak_valid", 32'(bus.o_tx_data_valid), 32'd1);
        check("rsv_nak_byte",  32'(bus.o_tx_data),       32'(EXP_NAK));
        check("rsv_no_rd",     32'(bus.o_rd_req),        32'd0);
        wait_idle("rsv");
        check("rsv_rd_count",  32'(rd_cnt), 32'd0);
        check("rsv_wr_count",  32'(wr_cnt), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog simulation did not complete within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [3:0]    hi;
        logic [3:0]    lo;
        int            kind, g0, g1;

        bus.i_rx_data       = '0;
        bus.i_rx_data_valid = 1'b0;
        bus.i_tx_ready      = 1'b1;
        bus.i_rd_data       = '0;
        clear_counts();

        repeat (3) @(negedge clk);
        check_reset_zero("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Read of address 2 with 0xBEEF.
        do_read(3'd2, 16'hBEEF, 0);
        // FIFO read, TX held off for several cycles.
        do_read(3'd0, 16'h5AC3, 5);
        // Write 0x1234 to address 1, back to back payload.
        do_write(3'd1, 16'h1234, 0, 0);
        // Longest gap that still beats the timeout.
        do_write(3'd6, 16'hA55A, TMO - 2, TMO - 2);
        do_timeout(1'b0);
        do_timeout(1'b1);
        do_reserved(8'h80);
        do_reserved(8'h10);

        // Reset in the middle of a payload.
        clear_counts();
        send_byte(8'h03);
        send_byte(8'h34);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_zero("rst_payload");
        rst_n = 1'b1;
        do_read(3'd2, 16'hC0DE, 0);

        // Reset while a TX byte is stalled.
        clear_counts();
        bus.i_rd_data  = 16'h7711;
        bus.i_tx_ready = 1'b0;
        send_byte(8'h0A);
        repeat (3) @(negedge clk);
        check("rst_stall_valid", 32'(bus.o_tx_data_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_zero("rst_stall");
        rst_n = 1'b1;
        bus.i_tx_ready = 1'b1;
        do_read(3'd5, 16'h0F0E, 2);

        // Randomised mix of commands.
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 2);
            a    = AW'($urandom_range(0, 7));
            d    = DW'($urandom);
            case (kind)
                0: do_read(a, d, $urandom_range(0, 4));
                1: begin
                    g0 = ($urandom_range(0, 7) == 0) ? TMO - 2 : $urandom_range(0, 3);
                    g1 = ($urandom_range(0, 7) == 0) ? TMO - 2 : $urandom_range(0, 3);
                    do_write(a, d, g0, g1);
                end
                default: begin
                    hi = 4'($urandom_range(1, 15));
                    lo = 4'($urandom_range(0, 15));
                    do_reserved({hi, lo});
                end
            endcase
        end

        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
